// File: rtl/id_regfile_scoreboard_if.sv
// Bus between the ID/WB stages and the ID register file with its pending-write scoreboard.
interface id_regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0]      raddr1;
  logic [ADDR_W-1:0]      raddr2;
  logic [15:0]            imm;
  logic                   ext_zero;
  logic                   we;
  logic [ADDR_W-1:0]      waddr;
  logic [DATA_W-1:0]      wdata;
  logic                   rsv_en;
  logic [ADDR_W-1:0]      rsv_addr;
  logic [DATA_W-1:0]      rdata1;
  logic [DATA_W-1:0]      rdata2;
  logic [DATA_W-1:0]      ext_imm;
  logic                   busy1;
  logic                   busy2;
  logic [2**ADDR_W-1:0]   pending;

  modport master (
    output raddr1, raddr2, imm, ext_zero, we, waddr, wdata, rsv_en, rsv_addr,
    input  rdata1, rdata2, ext_imm, busy1, busy2, pending
  );

  modport slave (
    input  raddr1, raddr2, imm, ext_zero, we, waddr, wdata, rsv_en, rsv_addr,
    output rdata1, rdata2, ext_imm, busy1, busy2, pending
  );
endinterface

// File: rtl/id_regfile_scoreboard.sv
// ID-stage register file: two async read ports, one WB write port, RAW scoreboard, imm extender.
// Optional write-through bypass from WB to the read ports: define ID_REGFILE_BYPASS_EN.
module id_regfile_scoreboard #(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 5,
  parameter int          SP_IDX  = 29,
  parameter logic [31:0] SP_INIT = 32'h8000_0000
) (
  input logic                     clk,
  input logic                     rst_n,
  id_regfile_scoreboard_if.slave  bus
);
  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_INIT);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending_q;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              busy1_c;
  logic              busy2_c;

  // Register 0 is only ever loaded with zero at reset and never written afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= (i == SP_IDX && i != 0) ? SP_RESET : '0;
      end
    end else if (bus.we && bus.waddr != '0) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  // A reservation beats a same-edge writeback: the reserving instruction is the younger producer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q[0] <= 1'b0;
      for (int i = 1; i < DEPTH; i++) begin
        if (bus.rsv_en && bus.rsv_addr == ADDR_W'(i)) begin
          pending_q[i] <= 1'b1;
        end else if (bus.we && bus.waddr == ADDR_W'(i)) begin
          pending_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rd1     = (bus.raddr1 == '0) ? '0 : regs[bus.raddr1];
    rd2     = (bus.raddr2 == '0) ? '0 : regs[bus.raddr2];
    busy1_c = pending_q[bus.raddr1];
    busy2_c = pending_q[bus.raddr2];
`ifdef ID_REGFILE_BYPASS_EN
    if (bus.we && bus.waddr != '0 && bus.waddr == bus.raddr1) rd1 = bus.wdata;
    if (bus.we && bus.waddr != '0 && bus.waddr == bus.raddr2) rd2 = bus.wdata;
    if (bus.we && bus.waddr == bus.raddr1 && !(bus.rsv_en && bus.rsv_addr == bus.raddr1))
      busy1_c = 1'b0;
    if (bus.we && bus.waddr == bus.raddr2 && !(bus.rsv_en && bus.rsv_addr == bus.raddr2))
      busy2_c = 1'b0;
`endif
  end

  assign bus.rdata1  = rd1;
  assign bus.rdata2  = rd2;
  assign bus.busy1   = busy1_c;
  assign bus.busy2   = busy2_c;
  assign bus.pending = pending_q;

  generate
    if (DATA_W > 16) begin : g_ext_wide
      assign bus.ext_imm = {{(DATA_W-16){bus.imm[15] & ~bus.ext_zero}}, bus.imm};
    end else begin : g_ext_narrow
      assign bus.ext_imm = bus.imm;
    end
  endgenerate
endmodule

// File: tb/tb_id_regfile_scoreboard.sv
// Self-checking bench for id_regfile_scoreboard; expected values queued at drive time, popped at check.
module tb_id_regfile_scoreboard;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
`ifdef ID_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_regfile_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  id_regfile_scoreboard #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SP_IDX(29), .SP_INIT(32'h8000_0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_q [$];
  string       name_q [$];
  logic [31:0] e;
  string       n;

  task automatic push_exp(input string nm, input logic [31:0] v);
    name_q.push_back(nm);
    exp_q.push_back(v);
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.rsv_en = 1'b0; bus.rsv_addr = '0;
  endtask

  task automatic pop_exp();
    n = name_q.pop_front();
    e = exp_q.pop_front();
    vectors++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.we = 1'b1; bus.waddr = 5'd29; bus.wdata = 32'h1111_1111;
    @(negedge clk);
    bus.waddr = 5'd5; bus.wdata = 32'h2222_2222; bus.rsv_en = 1'b1; bus.rsv_addr = 5'd4;
    @(negedge clk);
    idle();
    bus.raddr1 = 5'd29; bus.raddr2 = 5'd5;
    push_exp("preload_sp", 32'h1111_1111);
    push_exp("preload_pending", 32'h0000_0010);
    #1;
    pop_exp(); if (bus.rdata1 !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.rdata1, e); end
    pop_exp(); if (bus.pending !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.pending, e); end
    push_exp("reset_sp", 32'h8000_0000);
    push_exp("reset_r5", 32'h0);
    push_exp("reset_pending", 32'h0);
    #1 rst_n = 1'b0;
    #1;
    pop_exp(); if (bus.rdata1 !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.rdata1, e); end
    pop_exp(); if (bus.rdata2 !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.rdata2, e); end
    pop_exp(); if (bus.pending !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.pending, e); end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    bus.raddr1 = 5'd5; bus.raddr2 = 5'd31;
    bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'hDEAD_BEEF;
    push_exp("wr_incycle", BYP ? 32'hDEAD_BEEF : 32'h0);
    #1;
    pop_exp(); if (bus.rdata1 !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.rdata1, e); end
    @(posedge clk); #1;
    idle();
    push_exp("wr_after", 32'hDEAD_BEEF);
    pop_exp(); if (bus.rdata1 !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.rdata1, e); end
    @(negedge clk);
    bus.we = 1'b1; bus.waddr = 5'd31; bus.wdata = 32'h0BAD_F00D;
    push_exp("wr_r31", 32'h0BAD_F00D);
    push_exp("wr_r5_hold", 32'hDEAD_BEEF);
    @(posedge clk); #1;
    idle();
    pop_exp(); if (bus.rdata2 !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.rdata2, e); end
    pop_exp(); if (bus.rdata1 !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.rdata1, e); end
  endtask

  task automatic test_reg0();
    @(negedge clk);
    bus.raddr1 = 5'd0;
    bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'h0000_1234;
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0;
    push_exp("r0_incycle", 32'h0);
    #1;
    pop_exp(); if (bus.rdata1 !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.rdata1, e); end
    push_exp("r0_read", 32'h0);
    push_exp("r0_pending", 32'h0);
    @(posedge clk); #1;
    idle();
    pop_exp(); if (bus.rdata1 !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.rdata1, e); end
    pop_exp(); if (bus.pending !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.pending, e); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    bus.raddr2 = 5'd7; bus.rsv_en = 1'b1; bus.rsv_addr = 5'd7;
    push_exp("sb_busy_pre", 32'h0);
    #1;
    pop_exp(); if (32'(bus.busy2) !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.busy2, e); end
    push_exp("sb_busy_set", 32'h1);
    push_exp("sb_pending_set", 32'h0000_0080);
    @(posedge clk); #1;
    idle();
    pop_exp(); if (32'(bus.busy2) !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.busy2, e); end
    pop_exp(); if (bus.pending !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.pending, e); end
    push_exp("sb_busy_hold", 32'h1);
    repeat (2) @(posedge clk);
    #1;
    pop_exp(); if (32'(bus.busy2) !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.busy2, e); end
    @(negedge clk);
    bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h7777_0007;
    push_exp("sb_busy_wb_cycle", BYP ? 32'h0 : 32'h1);
    #1;
    pop_exp(); if (32'(bus.busy2) !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.busy2, e); end
    push_exp("sb_busy_clr", 32'h0);
    push_exp("sb_pending_clr", 32'h0);
    @(posedge clk); #1;
    idle();
    pop_exp(); if (32'(bus.busy2) !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.busy2, e); end
    pop_exp(); if (bus.pending !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.pending, e); end
    // Same-edge reserve and writeback of reg 7: the reservation must survive.
    @(negedge clk);
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd7;
    bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h7777_1007;
    push_exp("sb_set_wins", 32'h0000_0080);
    push_exp("sb_set_wins_data", 32'h7777_1007);
    @(posedge clk); #1;
    idle();
    pop_exp(); if (bus.pending !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.pending, e); end
    pop_exp(); if (bus.rdata2 !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.rdata2, e); end
    @(negedge clk);
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd7;
    bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h0000_0099; bus.raddr1 = 5'd9;
    push_exp("sb_rereserve", 32'h0000_0080);
    push_exp("sb_nonpending_write", 32'h0000_0099);
    @(posedge clk); #1;
    idle();
    pop_exp(); if (bus.pending !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.pending, e); end
    pop_exp(); if (bus.rdata1 !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.rdata1, e); end
    @(negedge clk);
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd12;
    bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h7777_2007; bus.raddr1 = 5'd12;
    push_exp("sb_indep", 32'h0000_1000);
    push_exp("sb_busy1", 32'h1);
    @(posedge clk); #1;
    idle();
    pop_exp(); if (bus.pending !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.pending, e); end
    pop_exp(); if (32'(bus.busy1) !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.busy1, e); end
    @(negedge clk);
    bus.we = 1'b1; bus.waddr = 5'd12; bus.wdata = 32'h0000_0C0C;
    push_exp("sb_final", 32'h0);
    @(posedge clk); #1;
    idle();
    pop_exp(); if (bus.pending !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.pending, e); end
  endtask

  task automatic test_extender();
    logic [15:0] imms [5];
    logic        ezs  [5];
    logic [31:0] exps [5];
    imms[0] = 16'h8001; ezs[0] = 1'b0; exps[0] = 32'hFFFF_8001;
    imms[1] = 16'h8001; ezs[1] = 1'b1; exps[1] = 32'h0000_8001;
    imms[2] = 16'h7FFF; ezs[2] = 1'b0; exps[2] = 32'h0000_7FFF;
    imms[3] = 16'hFFFF; ezs[3] = 1'b1; exps[3] = 32'h0000_FFFF;
    imms[4] = 16'hFFFF; ezs[4] = 1'b0; exps[4] = 32'hFFFF_FFFF;
    for (int k = 0; k < 5; k++) begin
      bus.imm = imms[k]; bus.ext_zero = ezs[k];
      push_exp($sformatf("ext_%0d", k), exps[k]);
      #1;
      pop_exp(); if (bus.ext_imm !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.ext_imm, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      d = $urandom;
      bus.we = 1'b1; bus.waddr = ADDR_W'(k); bus.wdata = d;
      bus.raddr1 = ADDR_W'(k - 1);
      #1;
      if (k > 1) begin
        pop_exp(); if (bus.rdata1 !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.rdata1, e); end
      end
      push_exp($sformatf("b2b_r%0d", k), d);
    end
    @(negedge clk);
    idle();
    bus.raddr1 = 5'd8;
    #1;
    pop_exp(); if (bus.rdata1 !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.rdata1, e); end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
    push_exp("mid_pending_pre", 32'h0000_0008);
    @(posedge clk); #1;
    idle();
    pop_exp(); if (bus.pending !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.pending, e); end
    @(negedge clk);
    bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'hAAAA_5555;
    bus.raddr1 = 5'd3; bus.raddr2 = 5'd29;
    #2 rst_n = 1'b0;
    push_exp("mid_reg3", 32'h0);
    push_exp("mid_pending", 32'h0);
    push_exp("mid_sp", 32'h8000_0000);
    @(posedge clk); #1;
    idle();
    pop_exp(); if (bus.rdata1 !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.rdata1, e); end
    pop_exp(); if (bus.pending !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.pending, e); end
    pop_exp(); if (bus.rdata2 !== e) begin miscompares++; $display("[TB] FAIL %s: got %h want %h", n, bus.rdata2, e); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, limit 100000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle();
    bus.raddr1 = '0; bus.raddr2 = '0; bus.imm = '0; bus.ext_zero = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_write_read();
    test_reg0();
    test_scoreboard();
    test_extender();
    test_back_to_back();
    test_reset_mid_op();
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d leftover entries want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
